alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between two requesters: port 0, the core execute stage, and port 1, the auxiliary unit (address/debug). It runs one operation at a time through a three-state sequencer, registers the operands and the result, and returns each result to the requester that issued it over a valid/ready handshake. It sits between the requesters and the ALU instance and drives the ALU's `ALUOp`, `A` and `B` inputs. Op encodings come from the `definitions` package.

## Interface
- `OP_W`, 4: ALU opcode width; matches `ALUOp`.
- `DW`, 8: operand and result width.

- `clk`  in  1  Single clock; all state updates on its rising edge.
- `reset`  in  1  Synchronous, active-high; sampled on the rising edge of `clk`.
- `req0_valid`, `req1_valid`  in  1  Request pending on port 0 / port 1.
- `req0_op`, `req1_op`  in  OP_W  Requested ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DW  Operands.
- `req0_ready`, `req1_ready`  out  1  Grant. A request is accepted when valid & ready.
- `rsp0_valid`, `rsp1_valid`  out  1  Result available for port 0 / port 1.
- `rsp0_ready`, `rsp1_ready`  in  1  Requester accepts the result.
- `rsp_data`  out  DW  Shared result bus.
- `rsp_carry`  out  1  Shared carry result.
- `alu_op`  out  OP_W  Drives ALU `ALUOp`.
- `alu_a`, `alu_b`  out  DW  Drive ALU `A` and `B`.
- `alu_out`  in  DW  ALU `Out`.
- `alu_carry`  in  1  ALU `CarryOut`.
- `busy`  out  1  High whenever the state is not IDLE.

## Operation
- The sequencer has three states: IDLE, EXEC and RESP.
- **IDLE**
  - `reqN_ready` = 1 only for the granted port. It is combinational from the valid inputs and the round-robin pointer.
  - If one port is valid, that port is granted.
  - If both ports are valid, the port other than `last_grant` is granted.
  - On acceptance: capture op/a/b into `alu_op`/`alu_a`/`alu_b`, record the owner, set `last_grant` to the owner, and go to EXEC.
  - If no port is valid, stay in IDLE.
- **EXEC**
  - The ALU evaluates the registered operands.
  - At the end of the cycle, capture `alu_out` into `rsp_data` and `alu_carry` into `rsp_carry`. Go to RESP.
  - Both ready outputs are 0.
- **RESP**
  - `rspN_valid` = 1 for the owner only. `rsp_data`/`rsp_carry` are held stable.
  - When `rspN_ready` is seen with valid high: go to IDLE.
  - Otherwise stay in RESP indefinitely (backpressure). The other port's request waits.
- No new grant is issued in the RESP state, even in the handshake cycle.
- `alu_op`/`alu_a`/`alu_b` hold their last issued values outside EXEC.
- Widths:
  - The result is exactly DW bits as produced by the ALU. No extension or truncation is done here.
  - The carry is passed through unmodified.
- The arbiter does not check opcode legality. Unknown opcodes go to the ALU as-is.
- Requesters hold valid, op and operands stable until accepted. A valid that drops before acceptance is simply not granted.

## Timing
- Reset values:
  - State IDLE.
  - `alu_op`, `alu_a`, `alu_b`, `rsp_data` = 0; `rsp_carry` = 0.
  - Both `rspN_valid` = 0; `busy` = 0.
  - Owner = 0; `last_grant` = 1, so port 0 wins the first tie.
- Latency: request accepted in cycle N → `rsp_valid` high in cycle N+2.
- Minimum issue interval is 3 cycles: accept in N, response handshake in N+2, next accept in N+3.
- Reset asserted in any state, including mid-EXEC or mid-RESP:
  - Return to the reset values on that edge.
  - The in-flight operation is discarded and no response is issued.
  - The pending requester must re-request.
- A `rspN_ready` that arrives before `rspN_valid` is ignored.

## Test plan
- Port 0 issues `kADD`, a=8'h01, b=8'h22 → `req0_ready` in cycle N; `rsp0_valid` in N+2 with `rsp_data`=8'h23, `rsp_carry`=0; `busy` high in N+1..N+2.
- Port 1 issues `kADD`, 8'hFF + 8'h01 → `rsp1_valid` with `rsp_data`=8'h00, `rsp_carry`=1; `rsp0_valid` stays 0 throughout.
- Both ports valid right after reset (port 0 `kPASS_INPUTB`, b=8'h01; port 1 `kPASS_INPUTA`, a=8'h5A), responses always accepted:
  - Port 0 granted first and returns 8'h01.
  - Port 1 is granted 3 cycles later and returns 8'h5A.
  - With both held valid, grants then alternate 0,1,0,1.
- Backpressure: hold `rsp0_ready`=0 for 5 cycles with port 1 valid:
  - `rsp0_valid` and `rsp_data` stay stable; `req1_ready` stays 0.
  - After the handshake, port 1 is granted in the next cycle.
- Assert `reset` during EXEC → next cycle: IDLE, all outputs at reset values, no `rsp_valid` ever issued for the discarded op.
- Idle with no valids for 10 cycles → `busy`=0, both readies 0, `alu_*` unchanged.

Source files
------------

// File: rtl/definitions.sv
// Opcode encodings shared by the ALU, the arbiter and anything that builds requests.
package definitions;

  typedef enum logic [3:0] {
    kADD         = 4'd0,
    kSUB         = 4'd1,
    kAND         = 4'd2,
    kOR          = 4'd3,
    kXOR         = 4'd4,
    kNOT_A       = 4'd5,
    kPASS_INPUTA = 4'd6,
    kPASS_INPUTB = 4'd7,
    kSHL         = 4'd8,
    kSHR         = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
interface alu_arbiter_if #(
  parameter int OP_W = 4,
  parameter int DW   = 8
);

  logic            req0_valid, req1_valid;
  logic [OP_W-1:0] req0_op, req1_op;
  logic [DW-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic            req0_ready, req1_ready;
  logic            rsp0_valid, rsp1_valid;
  logic            rsp0_ready, rsp1_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_carry;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_data, rsp_carry
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_carry
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// one operation in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter #(
  parameter int OP_W = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  alu_arbiter_if.slave    bus,
  output logic [OP_W-1:0] alu_op,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_carry,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            grant0, grant1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the port that did not win last time is served.
        if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
          grant0 = 1'b1;
        end else if (bus.req1_valid) begin
          grant1 = 1'b1;
        end

        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          alu_op_d     = grant1 ? bus.req1_op : bus.req0_op;
          alu_a_d      = grant1 ? bus.req1_a  : bus.req0_a;
          alu_b_d      = grant1 ? bus.req1_b  : bus.req0_b;
          state_d      = ST_EXEC;
        end
      end

      ST_EXEC: begin
        rsp_data_d  = alu_out;
        rsp_carry_d = alu_carry;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_alu_arbiter;
  import definitions::*;

  localparam int OP_W = 4;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [OP_W-1:0] alu_op;
  logic [DW-1:0]   alu_a, alu_b, alu_out;
  logic            alu_carry, busy;

  alu_arbiter_if #(.OP_W(OP_W), .DW(DW)) bus ();

  alu_arbiter #(.OP_W(OP_W), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result}.
  function automatic logic [DW:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      kADD:         return {1'b0, a} + {1'b0, b};
      kSUB:         return {1'b0, a} - {1'b0, b};
      kAND:         return {1'b0, a & b};
      kOR:          return {1'b0, a | b};
      kXOR:         return {1'b0, a ^ b};
      kNOT_A:       return {1'b0, ~a};
      kPASS_INPUTA: return {1'b0, a};
      kPASS_INPUTB: return {1'b0, b};
      kSHL:         return {a, 1'b0};
      kSHR:         return {a[0], 1'b0, a[DW-1:1]};
      default:      return '0;
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_f(alu_op, alu_a, alu_b);

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    logic          carry;
  } exp_t;

  exp_t            exp_q[$];
  bit              grant_log[$];
  bit              m_live     = 1'b0;
  bit              m_inflight = 1'b0;
  bit              m_owner    = 1'b0;
  bit              m_last     = 1'b1;
  bit              m_resp     = 1'b0;   // result has been latched and is being offered
  logic [3:0]      m_op;
  logic [DW-1:0]   m_a, m_b, m_data;
  logic            m_carry;
  logic            e_r0, e_r1, own_ready;
  logic [DW:0]     m_res;

  // Compare at the falling edge, then advance the model by what the next rising edge does.
  always @(negedge clk) begin
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (!m_inflight) begin
      if (bus.req0_valid && bus.req1_valid) begin
        e_r0 = m_last;
        e_r1 = !m_last;
      end else begin
        e_r0 = bus.req0_valid;
        e_r1 = bus.req1_valid;
      end
    end

    if (bus.req0_valid && bus.req0_ready) grant_log.push_back(1'b0);
    if (bus.req1_valid && bus.req1_ready) grant_log.push_back(1'b1);

    if (m_live) begin
      check("req0_ready", bus.req0_ready, e_r0);
      check("req1_ready", bus.req1_ready, e_r1);
      check("rsp0_valid", bus.rsp0_valid, m_resp && !m_owner);
      check("rsp1_valid", bus.rsp1_valid, m_resp &&  m_owner);
      check("busy",       busy,           m_inflight);
      check("alu_op",     alu_op,         m_op);
      check("alu_a",      alu_a,          m_a);
      check("alu_b",      alu_b,          m_b);
      check("rsp_data",   bus.rsp_data,   m_data);
      check("rsp_carry",  bus.rsp_carry,  m_carry);
      if (m_resp) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          check("sb_port",  bus.rsp1_valid, exp_q[0].port);
          check("sb_data",  bus.rsp_data,   exp_q[0].data);
          check("sb_carry", bus.rsp_carry,  exp_q[0].carry);
        end
      end
    end

    if (reset) begin
      m_live = 1'b1; m_inflight = 1'b0; m_resp = 1'b0; m_owner = 1'b0; m_last = 1'b1;
      m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_carry = 1'b0;
      exp_q.delete();
    end else if (m_live) begin
      own_ready = m_owner ? bus.rsp1_ready : bus.rsp0_ready;
      if (!m_inflight) begin
        if (e_r0 || e_r1) begin
          m_owner = e_r1;
          m_last  = e_r1;
          m_op    = e_r1 ? bus.req1_op : bus.req0_op;
          m_a     = e_r1 ? bus.req1_a  : bus.req0_a;
          m_b     = e_r1 ? bus.req1_b  : bus.req0_b;
          m_res   = alu_f(m_op, m_a, m_b);
          exp_q.push_back('{port: e_r1, data: m_res[DW-1:0], carry: m_res[DW]});
          m_inflight = 1'b1;
        end
      end else if (!m_resp) begin
        m_data  = exp_q[0].data;
        m_carry = exp_q[0].carry;
        m_resp  = 1'b1;
      end else if (own_ready) begin
        void'(exp_q.pop_front());
        m_inflight = 1'b0;
        m_resp     = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit p, input bit v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (p) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input bit p, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit done;
    done = 1'b0;
    set_port(p, 1'b1, op, a, b);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (p ? bus.req1_ready : bus.req0_ready) done = 1'b1;
      tick();
    end
    if (!done) check("issue_timeout", 32'd0, 32'd1);
    set_port(p, 1'b0, op, a, b);
  endtask

  logic [31:0] r;
  bit          acc0, acc1;

  initial begin
    reset = 1'b1;
    set_port(1'b0, 1'b0, '0, '0, '0);
    set_port(1'b1, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    do_reset();

    // Single requests on each port.
    issue(1'b0, kADD, 8'h01, 8'h22);
    repeat (3) tick();
    issue(1'b1, kADD, 8'hFF, 8'h01);
    repeat (3) tick();

    // Both valid straight out of reset: port 0 wins, then strict alternation.
    do_reset();
    grant_log.delete();
    set_port(1'b0, 1'b1, kPASS_INPUTB, 8'h00, 8'h01);
    set_port(1'b1, 1'b1, kPASS_INPUTA, 8'h5A, 8'h00);
    repeat (14) tick();
    set_port(1'b0, 1'b0, '0, '0, '0);
    set_port(1'b1, 1'b0, '0, '0, '0);
    check("tie_grant_count", (grant_log.size() >= 4), 1);
    if (grant_log.size() >= 4) begin
      check("tie_grant0", grant_log[0], 0);
      check("tie_grant1", grant_log[1], 1);
      check("tie_grant2", grant_log[2], 0);
      check("tie_grant3", grant_log[3], 1);
    end
    repeat (4) tick();

    // Backpressure on port 0 while port 1 waits.
    do_reset();
    bus.rsp0_ready = 1'b0;
    set_port(1'b0, 1'b1, kXOR, 8'hA5, 8'h3C);
    set_port(1'b1, 1'b1, kSUB, 8'h10, 8'h20);
    tick();
    set_port(1'b0, 1'b0, '0, '0, '0);
    repeat (7) tick();
    bus.rsp0_ready = 1'b1;
    grant_log.delete();
    tick();
    tick();
    check("bp_port1_granted", (grant_log.size() == 1) && grant_log[0], 1);
    set_port(1'b1, 1'b0, '0, '0, '0);
    repeat (4) tick();

    // Reset while the operation is in EXEC: it must vanish.
    issue(1'b0, kSHL, 8'h81, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();

    // Quiet period.
    repeat (10) tick();

    // Random traffic, requests held until accepted, occasional reset.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      tick();
      reset = ($urandom_range(99) == 0);
      if (acc0 || !bus.req0_valid) begin
        r = $urandom;
        set_port(1'b0, ($urandom_range(99) < 45), r[3:0], r[15:8], r[23:16]);
      end
      if (acc1 || !bus.req1_valid) begin
        r = $urandom;
        set_port(1'b1, ($urandom_range(99) < 45), r[3:0], r[15:8], r[23:16]);
      end
      bus.rsp0_ready = ($urandom_range(99) < 60);
      bus.rsp1_ready = ($urandom_range(99) < 60);
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
